// File: rtl/ctrl_pkg.sv
// Shared types for the multicycle RV32I controller: state encoding, opcodes and datapath mux encodings.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    CSR      = 4'd11,
    TRAP     = 4'd12
  } state_t;

  localparam logic [6:0] OP_LW     = 7'd3;
  localparam logic [6:0] OP_SW     = 7'd35;
  localparam logic [6:0] OP_RTYPE  = 7'd51;
  localparam logic [6:0] OP_BTYPE  = 7'd99;
  localparam logic [6:0] OP_ITYPE  = 7'd19;
  localparam logic [6:0] OP_JAL    = 7'd111;
  localparam logic [6:0] OP_SYSTEM = 7'd115;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] MOCSR_CSR = 2'b01;

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Controller <-> datapath bundle: opcode/flags in, mux selects and strobes out.
interface mc_ctrl_fsm_if;
  logic [6:0] op;
  logic       zero;
  logic       memReady;
  logic       memReq;
  logic       adrSrc;
  logic       memWrite;
  logic       irWrite;
  logic       pcWrite;
  logic [1:0] resSrc;
  logic [1:0] aluSrcA;
  logic [1:0] aluSrcB;
  logic [1:0] aluOp;
  logic [1:0] inmSrc;
  logic       regWrite;
  logic [1:0] mocsr;
  logic       retire;
  logic       illegal;

  modport master (
    input  op, zero, memReady,
    output memReq, adrSrc, memWrite, irWrite, pcWrite, resSrc, aluSrcA, aluSrcB,
           aluOp, inmSrc, regWrite, mocsr, retire, illegal
  );

  modport slave (
    output op, zero, memReady,
    input  memReq, adrSrc, memWrite, irWrite, pcWrite, resSrc, aluSrcA, aluSrcB,
           aluOp, inmSrc, regWrite, mocsr, retire, illegal
  );
endinterface

// File: rtl/imm_src_deco.sv
// Immediate-format select decoded straight from the opcode; purely combinational, state independent.
module imm_src_deco
  import ctrl_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] inmSrc
);

  always_comb begin
    inmSrc = IMM_I;
    case (op)
      OP_LW, OP_ITYPE, OP_SYSTEM: inmSrc = IMM_I;
      OP_SW:                      inmSrc = IMM_S;
      OP_BTYPE:                   inmSrc = IMM_B;
      OP_JAL:                     inmSrc = IMM_J;
      default:                    inmSrc = IMM_I;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle sequencer: 3-5 cycles per instruction plus one per memReady=0 cycle in FETCH/MEMREAD/MEMWRITE.
// Memory waits hold state and all selects stable; reset masks every strobe in the same cycle.
module mc_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter bit CSR_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  mc_ctrl_fsm_if.master bus
);

  state_t     state;
  state_t     stateNext;
  logic       memReqRaw;
  logic       adrSrc;
  logic       memWriteRaw;
  logic       irWriteRaw;
  logic       pcUpdate;
  logic       branch;
  logic [1:0] resSrc;
  logic [1:0] aluSrcA;
  logic [1:0] aluSrcB;
  logic [1:0] aluOp;
  logic       regWriteRaw;
  logic [1:0] mocsr;
  logic       retireRaw;
  logic       illegal;
  logic [1:0] inmSrc;

  imm_src_deco uImmSrc (
    .op     (bus.op),
    .inmSrc (inmSrc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= FETCH;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext   = state;
    memReqRaw   = 1'b0;
    adrSrc      = 1'b0;
    memWriteRaw = 1'b0;
    irWriteRaw  = 1'b0;
    pcUpdate    = 1'b0;
    branch      = 1'b0;
    resSrc      = RES_ALUOUT;
    aluSrcA     = SRCA_PC;
    aluSrcB     = SRCB_RS2;
    aluOp       = ALUOP_ADD;
    regWriteRaw = 1'b0;
    mocsr       = 2'b00;
    retireRaw   = 1'b0;
    illegal     = 1'b0;
    case (state)
      FETCH: begin
        memReqRaw  = 1'b1;
        aluSrcB    = SRCB_FOUR;
        resSrc     = RES_ALURES;
        irWriteRaw = bus.memReady;
        pcUpdate   = bus.memReady;
        if (bus.memReady) stateNext = DECODE;
      end
      DECODE: begin
        // Branch target computed here so BEQ can reuse ALUOut.
        aluSrcA = SRCA_OLDPC;
        aluSrcB = SRCB_IMM;
        case (bus.op)
          OP_LW, OP_SW: stateNext = MEMADR;
          OP_RTYPE:     stateNext = EXECR;
          OP_ITYPE:     stateNext = EXECI;
          OP_BTYPE:     stateNext = BEQ;
          OP_JAL:       stateNext = JAL;
          OP_SYSTEM:    stateNext = CSR_EN ? CSR : TRAP;
          default:      stateNext = TRAP;
        endcase
      end
      MEMADR: begin
        aluSrcA   = SRCA_RS1;
        aluSrcB   = SRCB_IMM;
        stateNext = (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        memReqRaw = 1'b1;
        adrSrc    = 1'b1;
        if (bus.memReady) stateNext = MEMWB;
      end
      MEMWB: begin
        resSrc      = RES_RDATA;
        regWriteRaw = 1'b1;
        retireRaw   = 1'b1;
        stateNext   = FETCH;
      end
      MEMWRITE: begin
        memReqRaw   = 1'b1;
        adrSrc      = 1'b1;
        memWriteRaw = 1'b1;
        retireRaw   = bus.memReady;
        if (bus.memReady) stateNext = FETCH;
      end
      EXECR: begin
        aluSrcA   = SRCA_RS1;
        aluSrcB   = SRCB_RS2;
        aluOp     = ALUOP_FUNCT;
        stateNext = ALUWB;
      end
      EXECI: begin
        aluSrcA   = SRCA_RS1;
        aluSrcB   = SRCB_IMM;
        aluOp     = ALUOP_FUNCT;
        stateNext = ALUWB;
      end
      ALUWB: begin
        resSrc      = RES_ALUOUT;
        regWriteRaw = 1'b1;
        retireRaw   = 1'b1;
        stateNext   = FETCH;
      end
      BEQ: begin
        aluSrcA   = SRCA_RS1;
        aluSrcB   = SRCB_RS2;
        aluOp     = ALUOP_BRANCH;
        branch    = 1'b1;
        retireRaw = 1'b1;
        stateNext = FETCH;
      end
      JAL: begin
        // Jump target already sits in ALUOut; ALU now forms oldPC+4 for rd.
        aluSrcA   = SRCA_OLDPC;
        aluSrcB   = SRCB_FOUR;
        pcUpdate  = 1'b1;
        stateNext = ALUWB;
      end
      CSR: begin
        regWriteRaw = 1'b1;
        resSrc      = RES_RDATA;
        mocsr       = MOCSR_CSR;
        retireRaw   = 1'b1;
        stateNext   = FETCH;
      end
      TRAP: begin
        illegal   = 1'b1;
        stateNext = TRAP;
      end
      default: stateNext = TRAP;
    endcase
  end

  // Strobes are gated by reset so an aborted instruction never writes.
  assign bus.memReq   = memReqRaw & rst_n;
  assign bus.memWrite = memWriteRaw & rst_n;
  assign bus.irWrite  = irWriteRaw & rst_n;
  assign bus.pcWrite  = (pcUpdate | (branch & bus.zero)) & rst_n;
  assign bus.regWrite = regWriteRaw & rst_n;
  assign bus.retire   = retireRaw & rst_n;
  assign bus.adrSrc   = adrSrc;
  assign bus.resSrc   = resSrc;
  assign bus.aluSrcA  = aluSrcA;
  assign bus.aluSrcB  = aluSrcB;
  assign bus.aluOp    = aluOp;
  assign bus.inmSrc   = inmSrc;
  assign bus.mocsr    = mocsr;
  assign bus.illegal  = illegal;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed vector bench for mc_ctrl_fsm: one CSR-enabled and one CSR-disabled instance in lockstep.
module tb_mc_ctrl_fsm;

  typedef struct packed {
    logic       memReq;
    logic       adrSrc;
    logic       memWrite;
    logic       irWrite;
    logic       pcWrite;
    logic [1:0] resSrc;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic       regWrite;
    logic [1:0] mocsr;
    logic       retire;
    logic       illegal;
  } outs_t;

  typedef struct {
    logic       rstN;
    logic [6:0] op;
    logic       zero;
    logic       memReady;
    outs_t      exp;
  } vec_t;

  localparam outs_t E_RST      = '{aluSrcB:2'b10, resSrc:2'b10, default:'0};
  localparam outs_t E_FETCH_W  = '{memReq:1'b1, aluSrcB:2'b10, resSrc:2'b10, default:'0};
  localparam outs_t E_FETCH_R  = '{memReq:1'b1, irWrite:1'b1, pcWrite:1'b1, aluSrcB:2'b10,
                                   resSrc:2'b10, default:'0};
  localparam outs_t E_DECODE   = '{aluSrcA:2'b01, aluSrcB:2'b01, default:'0};
  localparam outs_t E_MEMADR   = '{aluSrcA:2'b10, aluSrcB:2'b01, default:'0};
  localparam outs_t E_MEMRD    = '{memReq:1'b1, adrSrc:1'b1, default:'0};
  localparam outs_t E_MEMWB    = '{resSrc:2'b01, regWrite:1'b1, retire:1'b1, default:'0};
  localparam outs_t E_MEMWR_W  = '{memReq:1'b1, adrSrc:1'b1, memWrite:1'b1, default:'0};
  localparam outs_t E_MEMWR_R  = '{memReq:1'b1, adrSrc:1'b1, memWrite:1'b1, retire:1'b1,
                                   default:'0};
  localparam outs_t E_MEMWR_RS = '{adrSrc:1'b1, default:'0};
  localparam outs_t E_EXECR    = '{aluSrcA:2'b10, aluOp:2'b10, default:'0};
  localparam outs_t E_EXECI    = '{aluSrcA:2'b10, aluSrcB:2'b01, aluOp:2'b10, default:'0};
  localparam outs_t E_ALUWB    = '{regWrite:1'b1, retire:1'b1, default:'0};
  localparam outs_t E_BEQ0     = '{aluSrcA:2'b10, aluOp:2'b01, retire:1'b1, default:'0};
  localparam outs_t E_BEQ1     = '{aluSrcA:2'b10, aluOp:2'b01, retire:1'b1, pcWrite:1'b1,
                                   default:'0};
  localparam outs_t E_JAL      = '{aluSrcA:2'b01, aluSrcB:2'b10, pcWrite:1'b1, default:'0};
  localparam outs_t E_CSR      = '{regWrite:1'b1, resSrc:2'b01, mocsr:2'b01, retire:1'b1,
                                   default:'0};
  localparam outs_t E_TRAP     = '{illegal:1'b1, default:'0};

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   retires  = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  mc_ctrl_fsm_if busA ();
  mc_ctrl_fsm_if busB ();

  mc_ctrl_fsm #(.CSR_EN(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busA)
  );

  mc_ctrl_fsm #(.CSR_EN(1'b0)) dutNoCsr (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busB)
  );

  assign busB.op       = busA.op;
  assign busB.zero     = busA.zero;
  assign busB.memReady = busA.memReady;

  function automatic outs_t outsA();
    return '{busA.memReq, busA.adrSrc, busA.memWrite, busA.irWrite, busA.pcWrite, busA.resSrc,
             busA.aluSrcA, busA.aluSrcB, busA.aluOp, busA.regWrite, busA.mocsr, busA.retire,
             busA.illegal};
  endfunction

  function automatic outs_t outsB();
    return '{busB.memReq, busB.adrSrc, busB.memWrite, busB.irWrite, busB.pcWrite, busB.resSrc,
             busB.aluSrcA, busB.aluSrcB, busB.aluOp, busB.regWrite, busB.mocsr, busB.retire,
             busB.illegal};
  endfunction

  function automatic logic [1:0] immExp(input logic [6:0] op);
    case (op)
      7'd35:   return 2'b01;
      7'd99:   return 2'b10;
      7'd111:  return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  task automatic add(input logic rstN, input logic [6:0] op, input logic zero,
                     input logic memReady, input outs_t exp);
    vec_t v;
    v.rstN = rstN; v.op = op; v.zero = zero; v.memReady = memReady; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic checkOut(input string name, input int idx, input outs_t act, input outs_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] outputs act=%h exp=%h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rstN, input logic [6:0] op, input logic zero,
                       input logic memReady);
    @(negedge clk);
    rst_n         = rstN;
    busA.op       = op;
    busA.zero     = zero;
    busA.memReady = memReady;
    #1;
  endtask

  initial begin
    // R-type, zero wait states
    add(0, 7'd51, 0, 1, E_RST);
    add(1, 7'd51, 0, 1, E_FETCH_R);
    add(1, 7'd51, 0, 0, E_DECODE);
    add(1, 7'd51, 1, 1, E_EXECR);
    add(1, 7'd51, 0, 0, E_ALUWB);
    // lw with 2 fetch waits and 3 read waits: 10 cycles
    add(1, 7'd3, 0, 0, E_FETCH_W);
    add(1, 7'd3, 0, 0, E_FETCH_W);
    add(1, 7'd3, 0, 1, E_FETCH_R);
    add(1, 7'd3, 0, 1, E_DECODE);
    add(1, 7'd3, 0, 1, E_MEMADR);
    add(1, 7'd3, 0, 0, E_MEMRD);
    add(1, 7'd3, 0, 0, E_MEMRD);
    add(1, 7'd3, 0, 0, E_MEMRD);
    add(1, 7'd3, 0, 1, E_MEMRD);
    add(1, 7'd3, 0, 0, E_MEMWB);
    // sw with one write wait
    add(1, 7'd35, 0, 1, E_FETCH_R);
    add(1, 7'd35, 0, 0, E_DECODE);
    add(1, 7'd35, 0, 0, E_MEMADR);
    add(1, 7'd35, 0, 0, E_MEMWR_W);
    add(1, 7'd35, 0, 1, E_MEMWR_R);
    // beq taken, then not taken
    add(1, 7'd99, 0, 1, E_FETCH_R);
    add(1, 7'd99, 1, 1, E_DECODE);
    add(1, 7'd99, 1, 1, E_BEQ1);
    add(1, 7'd99, 1, 1, E_FETCH_R);
    add(1, 7'd99, 0, 1, E_DECODE);
    add(1, 7'd99, 0, 1, E_BEQ0);
    // jal
    add(1, 7'd111, 0, 1, E_FETCH_R);
    add(1, 7'd111, 0, 0, E_DECODE);
    add(1, 7'd111, 0, 0, E_JAL);
    add(1, 7'd111, 1, 0, E_ALUWB);
    // I-type
    add(1, 7'd19, 0, 1, E_FETCH_R);
    add(1, 7'd19, 0, 1, E_DECODE);
    add(1, 7'd19, 0, 1, E_EXECI);
    add(1, 7'd19, 0, 1, E_ALUWB);
    // CSR (enabled instance)
    add(1, 7'd115, 0, 1, E_FETCH_R);
    add(1, 7'd115, 0, 1, E_DECODE);
    add(1, 7'd115, 0, 1, E_CSR);
    // illegal opcode: sticky trap, then one reset edge
    add(1, 7'h7F, 0, 1, E_FETCH_R);
    add(1, 7'h7F, 0, 1, E_DECODE);
    for (int i = 0; i < 12; i++) add(1, 7'h7F, logic'(i % 2), logic'((i / 2) % 2), E_TRAP);
    add(0, 7'h7F, 0, 1, E_TRAP);
    add(1, 7'd51, 0, 0, E_FETCH_W);
    // reset during a stalled store
    add(1, 7'd35, 0, 1, E_FETCH_R);
    add(1, 7'd35, 0, 1, E_DECODE);
    add(1, 7'd35, 0, 0, E_MEMADR);
    add(1, 7'd35, 0, 0, E_MEMWR_W);
    add(0, 7'd35, 0, 0, E_MEMWR_RS);
    add(1, 7'd35, 0, 0, E_FETCH_W);

    rst_n         = 1'b0;
    busA.op       = 7'd51;
    busA.zero     = 1'b0;
    busA.memReady = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rstN, vecs[i].op, vecs[i].zero, vecs[i].memReady);
      checkOut("vec", i, outsA(), vecs[i].exp);
      checks++;
      if (busA.inmSrc !== immExp(vecs[i].op)) begin
        failures++;
        $display("FAIL inmSrc[%0d] act=%b exp=%b", i, busA.inmSrc, immExp(vecs[i].op));
      end
      if (busA.retire === 1'b1) retires++;
    end

    checks++;
    if (retires != 8) begin
      failures++;
      $display("FAIL retireCount act=%0d exp=8", retires);
    end

    // CSR opcode on both instances: enabled one runs CSR, disabled one traps
    drive(0, 7'd115, 0, 1);
    checkOut("csrA", 0, outsA(), E_RST);
    checkOut("csrB", 0, outsB(), E_RST);
    drive(1, 7'd115, 0, 1);
    checkOut("csrA", 1, outsA(), E_FETCH_R);
    checkOut("csrB", 1, outsB(), E_FETCH_R);
    drive(1, 7'd115, 0, 1);
    checkOut("csrA", 2, outsA(), E_DECODE);
    checkOut("csrB", 2, outsB(), E_DECODE);
    drive(1, 7'd115, 0, 1);
    checkOut("csrA", 3, outsA(), E_CSR);
    checkOut("csrB", 3, outsB(), E_TRAP);
    drive(1, 7'd115, 1, 1);
    checkOut("csrA", 4, outsA(), E_FETCH_R);
    checkOut("csrB", 4, outsB(), E_TRAP);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
